// File: rtl/axi_burst_mem_responder_pkg.sv
// Shared AXI types, request/response structs and burst helper functions
// for the burst-to-memory responder and its address generator.
package axi_burst_mem_responder_pkg;

  localparam int unsigned AXI_AW = 32;
  localparam int unsigned AXI_DW = 64;
  localparam int unsigned AXI_IW = 4;

  typedef logic [1:0] burst_t;
  typedef logic [1:0] resp_t;
  typedef logic [2:0] size_t;

  localparam burst_t BURST_FIXED = 2'b00;
  localparam burst_t BURST_INCR  = 2'b01;
  localparam burst_t BURST_WRAP  = 2'b10;
  localparam resp_t  RESP_OKAY   = 2'b00;
  localparam resp_t  RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AXI_IW-1:0] id;
    logic [AXI_AW-1:0] addr;
    logic [7:0]        len;
    size_t             size;
    burst_t            burst;
  } axi_ax_t;

  typedef struct packed {
    logic [AXI_DW-1:0]   data;
    logic [AXI_DW/8-1:0] strb;
    logic                last;
  } axi_w_t;

  typedef struct packed {
    logic [AXI_IW-1:0] id;
    resp_t             resp;
  } axi_b_t;

  typedef struct packed {
    logic [AXI_IW-1:0] id;
    logic [AXI_DW-1:0] data;
    resp_t             resp;
    logic              last;
  } axi_r_t;

  typedef struct packed {
    logic    aw_valid;
    axi_ax_t aw;
    logic    w_valid;
    axi_w_t  w;
    logic    b_ready;
    logic    ar_valid;
    axi_ax_t ar;
    logic    r_ready;
  } axi_req_pkg_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   r_valid;
    axi_r_t r;
  } axi_resp_pkg_t;

  function automatic logic [15:0] beat_bytes(input size_t size);
    return 16'd1 << size;
  endfunction

  // Only len[3:0] matters: legal WRAP lengths are 1, 3, 7 or 15.
  function automatic logic [15:0] wrap_boundary(input size_t size, input logic [7:0] len);
    return beat_bytes(size) * ({12'd0, len[3:0]} + 16'd1);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI next-beat address for FIXED, INCR and WRAP bursts.
module axi_burst_addr_gen
  import axi_burst_mem_responder_pkg::*;
#(
  parameter int unsigned AddrWidth = 32
) (
  input  logic [AddrWidth-1:0] addr_i,
  input  size_t                size_i,
  input  logic [7:0]           len_i,
  input  burst_t               burst_i,
  output logic [AddrWidth-1:0] next_addr_o
);
  localparam logic [AddrWidth-1:0] ONE = AddrWidth'(1);

  logic [AddrWidth-1:0] nbytes, bnd, aligned, incr;

  always_comb begin
    nbytes  = AddrWidth'(beat_bytes(size_i));
    bnd     = AddrWidth'(wrap_boundary(size_i, len_i));
    aligned = addr_i & ~(nbytes - ONE);
    incr    = aligned + nbytes;
    case (burst_i)
      BURST_INCR: next_addr_o = incr;
      BURST_WRAP: next_addr_o = (addr_i & ~(bnd - ONE)) | (incr & (bnd - ONE));
      default:    next_addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/axi_burst_mem_responder.sv
// AXI4 subordinate terminator: one burst at a time, broken into single-word
// req/gnt memory accesses; reads and writes share one sequencer.
module axi_burst_mem_responder
  import axi_burst_mem_responder_pkg::*;
#(
  parameter int unsigned AddrWidth  = AXI_AW,
  parameter int unsigned DataWidth  = AXI_DW,
  parameter int unsigned IdWidth    = AXI_IW,
  parameter type         axi_req_t  = axi_req_pkg_t,
  parameter type         axi_resp_t = axi_resp_pkg_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  axi_req_t               slv_req_i,
  output axi_resp_t              slv_resp_o,
  output logic                   mem_req_o,
  input  logic                   mem_gnt_i,
  output logic                   mem_we_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  input  logic                   mem_rvalid_i,
  input  logic [DataWidth-1:0]   mem_rdata_i
);
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned OffW      = $clog2(StrbWidth);
  localparam logic [AddrWidth-1:0] WORD_MASK = ~AddrWidth'(StrbWidth - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_DATA = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_WAIT = 3'd4;
  localparam logic [2:0] RD_RESP = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [IdWidth-1:0]   id_q, id_d;
  logic [AddrWidth-1:0] addr_q, addr_d, next_addr;
  logic [7:0]           len_q, len_d, cnt_q, cnt_d;
  size_t                size_q, size_d;
  burst_t               burst_q, burst_d;
  logic                 err_q, err_d, prio_q, prio_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;

  logic    aw_win, last_beat, ax_err;
  axi_ax_t ax;

  axi_burst_addr_gen #(.AddrWidth(AddrWidth)) i_addr_gen (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .len_i       (len_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr)
  );

  // prio_q = 0 favours AW, 1 favours AR when both are valid.
  assign aw_win     = slv_req_i.aw_valid && !(slv_req_i.ar_valid && prio_q);
  assign ax         = aw_win ? slv_req_i.aw : slv_req_i.ar;
  assign ax_err     = (ax.size > size_t'(OffW)) || (ax.burst == 2'b11) ||
                      (ax.burst == BURST_WRAP && !(ax.len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  assign last_beat  = (cnt_q == len_q);
  assign mem_addr_o = addr_q & WORD_MASK;

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    burst_d     = burst_q;
    err_d       = err_q;
    prio_d      = prio_q;
    rdata_d     = rdata_q;
    slv_resp_o  = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    case (state_q)
      IDLE: begin
        slv_resp_o.aw_ready = !(slv_req_i.ar_valid && prio_q);
        slv_resp_o.ar_ready = !(slv_req_i.aw_valid && !prio_q);
        if (slv_req_i.aw_valid || slv_req_i.ar_valid) begin
          id_d    = ax.id;
          addr_d  = ax.addr;
          len_d   = ax.len;
          size_d  = ax.size;
          burst_d = ax.burst;
          cnt_d   = '0;
          err_d   = ax_err;
          prio_d  = !prio_q;
          state_d = aw_win ? WR_DATA : RD_REQ;
        end
      end
      WR_DATA: begin
        if (err_q) begin
          slv_resp_o.w_ready = 1'b1;
        end else begin
          mem_req_o          = slv_req_i.w_valid;
          mem_we_o           = 1'b1;
          mem_wdata_o        = slv_req_i.w.data;
          mem_be_o           = slv_req_i.w.strb;
          slv_resp_o.w_ready = mem_gnt_i;
        end
        if (slv_req_i.w_valid && slv_resp_o.w_ready) begin
          addr_d = next_addr;
          cnt_d  = cnt_q + 8'd1;
          if (slv_req_i.w.last || last_beat) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        slv_resp_o.b_valid = 1'b1;
        slv_resp_o.b.id    = id_q;
        slv_resp_o.b.resp  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (slv_req_i.b_ready) state_d = IDLE;
      end
      RD_REQ: begin
        if (err_q) begin
          rdata_d = '0;
          state_d = RD_RESP;
        end else begin
          mem_req_o = 1'b1;
          mem_be_o  = '1;
          if (mem_gnt_i) state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (mem_rvalid_i) begin
          rdata_d = mem_rdata_i;
          state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        slv_resp_o.r_valid = 1'b1;
        slv_resp_o.r.id    = id_q;
        slv_resp_o.r.data  = rdata_q;
        slv_resp_o.r.resp  = err_q ? RESP_SLVERR : RESP_OKAY;
        slv_resp_o.r.last  = last_beat;
        if (slv_req_i.r_ready) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            addr_d  = next_addr;
            cnt_d   = cnt_q + 8'd1;
            state_d = RD_REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
      prio_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      err_q   <= err_d;
      prio_q  <= prio_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi_burst_mem_responder.sv
// Scoreboard bench: stimulus pushes expected memory/B/R items, a negedge
// monitor pops and compares them as the DUT presents each handshake.
module tb_axi_burst_mem_responder;
  import axi_burst_mem_responder_pkg::*;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
  } mem_exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  axi_req_pkg_t  req;
  axi_resp_pkg_t resp;
  logic          mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0]   mem_addr;
  logic [63:0]   mem_wdata, mem_rdata;
  logic [7:0]    mem_be;
  logic          stray;

  mem_exp_t mem_q[$];
  axi_r_t   r_q[$];
  axi_b_t   b_q[$];
  int checks = 0, errors = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_burst_mem_responder dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .slv_req_i    (req),
    .slv_resp_o   (resp),
    .mem_req_o    (mem_req),
    .mem_gnt_i    (mem_gnt),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_be_o     (mem_be),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata)
  );

  function automatic logic [63:0] memf(input logic [31:0] a);
    return {a ^ 32'h5A5A_5A5A, a};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Memory model: read data returned one cycle after the read grant.
  always begin
    logic g;
    logic [31:0] a;
    @(negedge clk);
    g = mem_req && mem_gnt && !mem_we && rst_n;
    a = mem_addr;
    @(posedge clk); #1;
    mem_rvalid = g || stray;
    mem_rdata  = g ? memf(a) : 64'hDEAD_BEEF_DEAD_BEEF;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req && mem_gnt) begin
        if (mem_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_unexpected got we=%b addr=%h want=none", mem_we, mem_addr);
        end else chk("mem", {mem_we, mem_addr, mem_wdata, mem_be}, mem_q.pop_front());
      end
      if (resp.r_valid && req.r_ready) begin
        if (r_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_unexpected got=%h want=none", resp.r);
        end else chk("r", resp.r, r_q.pop_front());
      end
      if (resp.b_valid && req.b_ready) begin
        if (b_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected got=%h want=none", resp.b);
        end else chk("b", resp.b, b_q.pop_front());
      end
    end
  end

  task automatic exp_mem(input logic we, input logic [31:0] a, input logic [63:0] d, input logic [7:0] be);
    mem_q.push_back('{we, a, d, be});
  endtask
  task automatic exp_rd(input logic [3:0] id, input logic [31:0] a, input logic last);
    exp_mem(1'b0, a, 64'd0, 8'hFF);
    r_q.push_back('{id, memf(a), RESP_OKAY, last});
  endtask

  task automatic ax_send(input bit is_w, input logic [3:0] id, input logic [31:0] a,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    bit hs;
    int n = 0;
    if (is_w) begin req.aw = '{id, a, len, size, burst}; req.aw_valid = 1'b1; end
    else      begin req.ar = '{id, a, len, size, burst}; req.ar_valid = 1'b1; end
    do begin
      @(negedge clk);
      hs = is_w ? resp.aw_ready : resp.ar_ready;
      tick();
      n++;
    end while (!hs && n < 50);
    req.aw_valid = 1'b0;
    req.ar_valid = 1'b0;
    if (!hs) begin checks++; errors++; $display("FAIL ax_timeout got=no_ready want=ready"); end
  endtask

  task automatic w_send(input logic [63:0] d, input logic [7:0] strb, input logic last);
    bit hs;
    int n = 0;
    req.w = '{d, strb, last};
    req.w_valid = 1'b1;
    do begin @(negedge clk); hs = resp.w_ready; tick(); n++; end while (!hs && n < 50);
    req.w_valid = 1'b0;
    if (!hs) begin checks++; errors++; $display("FAIL w_timeout got=no_ready want=ready"); end
  endtask

  task automatic drain();
    int n = 0;
    while ((mem_q.size() != 0 || r_q.size() != 0 || b_q.size() != 0) && n < 300) begin tick(); n++; end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL drain_timeout got mem=%0d r=%0d b=%0d want=0", mem_q.size(), r_q.size(), b_q.size());
      mem_q.delete(); r_q.delete(); b_q.delete();
    end
    repeat (2) tick();
  endtask

  task automatic wait_rvalid();
    int n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (resp.r_valid) break;
      tick(); n++;
    end
    if (n >= 50) begin checks++; errors++; $display("FAIL rvalid_timeout got=0 want=1"); end
  endtask

  initial begin
    int c0, n;
    req = '0; req.b_ready = 1'b1; req.r_ready = 1'b1;
    rst_n = 1'b0; mem_gnt = 1'b1; stray = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_state", {resp.b_valid, resp.r_valid, resp.w_ready, mem_req, mem_we}, 5'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // Simultaneous AW/AR: write wins first, then read.
    exp_mem(1'b1, 32'h300, 64'h0123_4567_89AB_CDEF, 8'hFF);
    b_q.push_back('{4'd1, RESP_OKAY});
    req.aw = '{4'd1, 32'h300, 8'd0, 3'd3, BURST_INCR}; req.aw_valid = 1'b1;
    req.ar = '{4'd2, 32'h380, 8'd0, 3'd3, BURST_INCR}; req.ar_valid = 1'b1;
    @(negedge clk);
    chk("arb_first", {resp.aw_ready, resp.ar_ready}, 2'b10);
    tick();
    req.aw_valid = 1'b0; req.ar_valid = 1'b0;
    w_send(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);
    drain();

    exp_rd(4'd4, 32'h380, 1'b1);
    req.aw = '{4'd3, 32'h310, 8'd0, 3'd3, BURST_INCR}; req.aw_valid = 1'b1;
    req.ar = '{4'd4, 32'h380, 8'd0, 3'd3, BURST_INCR}; req.ar_valid = 1'b1;
    @(negedge clk);
    chk("arb_second", {resp.aw_ready, resp.ar_ready}, 2'b01);
    tick();
    req.aw_valid = 1'b0; req.ar_valid = 1'b0;
    drain();

    // INCR write, 4 beats at one per cycle.
    for (int i = 0; i < 4; i++) exp_mem(1'b1, 32'h100 + 32'(8 * i), {32'hCAFE_0000 + 32'(i), 32'(i)}, 8'hFF);
    b_q.push_back('{4'd5, RESP_OKAY});
    ax_send(1'b1, 4'd5, 32'h100, 8'd3, 3'd3, BURST_INCR);
    c0 = cyc;
    for (int i = 0; i < 4; i++) w_send({32'hCAFE_0000 + 32'(i), 32'(i)}, 8'hFF, i == 3);
    chk("wr_tput", 32'(cyc - c0), 32'd4);
    drain();

    // WRAP read 0x118 -> 0x118, 0x100, 0x108, 0x110; 3 cycles per beat.
    exp_rd(4'd6, 32'h118, 1'b0);
    exp_rd(4'd6, 32'h100, 1'b0);
    exp_rd(4'd6, 32'h108, 1'b0);
    exp_rd(4'd6, 32'h110, 1'b1);
    ax_send(1'b0, 4'd6, 32'h118, 8'd3, 3'd3, BURST_WRAP);
    n = 0;
    while (r_q.size() != 0 && n < 100) begin tick(); n++; end
    chk("rd_tput", 32'(n), 32'd12);
    drain();

    // FIXED read, 3 beats at the same word.
    for (int i = 0; i < 3; i++) exp_rd(4'd7, 32'h40, i == 2);
    ax_send(1'b0, 4'd7, 32'h40, 8'd2, 3'd3, BURST_FIXED);
    drain();

    // Unaligned INCR start, size=2: 0x0C -> word 0x08, then 0x10.
    exp_rd(4'd13, 32'h08, 1'b0);
    exp_rd(4'd13, 32'h10, 1'b1);
    ax_send(1'b0, 4'd13, 32'h0C, 8'd1, 3'd2, BURST_INCR);
    drain();

    // Oversized write: drained without memory access, SLVERR.
    b_q.push_back('{4'd8, RESP_SLVERR});
    ax_send(1'b1, 4'd8, 32'h200, 8'd1, 3'd4, BURST_INCR);
    w_send(64'h1, 8'hFF, 1'b0);
    w_send(64'h2, 8'hFF, 1'b1);
    drain();

    // Illegal WRAP length: 3 SLVERR beats of zero data.
    for (int i = 0; i < 3; i++) r_q.push_back('{4'd9, 64'd0, RESP_SLVERR, i == 2});
    ax_send(1'b0, 4'd9, 32'h200, 8'd2, 3'd3, BURST_WRAP);
    drain();

    // R backpressure on the third beat.
    for (int i = 0; i < 4; i++) exp_rd(4'd10, 32'h400 + 32'(8 * i), i == 3);
    ax_send(1'b0, 4'd10, 32'h400, 8'd3, 3'd3, BURST_INCR);
    n = 0;
    while (r_q.size() > 2 && n < 100) begin tick(); n++; end
    req.r_ready = 1'b0;
    tick();
    wait_rvalid();
    for (int i = 0; i < 5; i++) begin
      chk("bp_r_hold", {resp.r_valid, resp.r}, {1'b1, r_q[0]});
      chk("bp_no_mem", {31'd0, mem_req}, 32'd0);
      tick();
      @(negedge clk);
    end
    tick();
    req.r_ready = 1'b1;
    drain();

    // Reset mid-burst, then a stray rvalid, then a normal read.
    exp_mem(1'b0, 32'h500, 64'd0, 8'hFF);
    req.r_ready = 1'b0;
    ax_send(1'b0, 4'd11, 32'h500, 8'd3, 3'd3, BURST_INCR);
    wait_rvalid();
    tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_mid", {resp.b_valid, resp.r_valid, resp.w_ready, mem_req, mem_we}, 5'b0);
    tick();
    mem_q.delete(); r_q.delete(); b_q.delete();
    req.r_ready = 1'b1;
    rst_n = 1'b1;
    stray = 1'b1;
    repeat (2) tick();
    stray = 1'b0;
    repeat (3) tick();
    exp_rd(4'd12, 32'h600, 1'b1);
    ax_send(1'b0, 4'd12, 32'h600, 8'd0, 3'd3, BURST_INCR);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
